// File: rtl/ftest_rx_pkg.sv
// Shared constants, control-state encoding and decode arithmetic for ftest_rx.
package ftest_rx_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int MAXW      = 64;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_t;

    // Works at MAXW bits; callers keep the low WIDTH bits of each half.
    function automatic logic [2*MAXW-1:0] decode(input logic [MAXW-1:0] a,
                                                 input logic [MAXW-1:0] z);
        logic [MAXW-1:0] b;
        b = ~z;
        return {b, a + b};
    endfunction

endpackage

// File: rtl/ftest_rx_fifo.sv
// Output buffer for ftest_rx: storage, wrapping pointers and occupancy.
module ftest_rx_fifo
    import ftest_rx_pkg::*;
#(
    parameter int DW    = 2 * WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Head entry read straight from storage flops, so it holds while not popped.
    assign rdata = mem[rptr];

endmodule

// File: rtl/ftest_rx.sv
// Receive-side decoder: recovers b and a+b from (a, z) into a small FIFO.
// Optional FTEST_RX_PARITY_EN adds out_par, the XOR-reduce of out_b.
module ftest_rx
    import ftest_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_b,
    output logic [WIDTH-1:0]         out_sum,
    output logic [$clog2(DEPTH):0]   level
`ifdef FTEST_RX_PARITY_EN
    ,
    output logic                     out_par
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;
`ifdef FTEST_RX_PARITY_EN
    localparam int DW = 2 * WIDTH + 1;
`else
    localparam int DW = 2 * WIDTH;
`endif

    state_t            state;
    state_t            state_nxt;
    logic              rdy_q;
    logic              push;
    logic              pop;
    logic [2*MAXW-1:0] dec;
    logic [WIDTH-1:0]  dec_b;
    logic [WIDTH-1:0]  dec_sum;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic              unused_dec;

    assign dec        = decode(MAXW'(in_a), MAXW'(in_z));
    assign dec_b      = dec[MAXW +: WIDTH];
    assign dec_sum    = dec[0 +: WIDTH];
    assign unused_dec = ^{dec[2*MAXW-1:MAXW+WIDTH], dec[MAXW-1:WIDTH]};

    // rdy_q keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
            state <= EMPTY;
        end else begin
            rdy_q <= 1'b1;
            state <= state_nxt;
        end
    end

    assign in_ready  = rdy_q && !flush && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (push) state_nxt = PARTIAL;
                PARTIAL: begin
                    if (push && !pop && level == LW'(DEPTH - 1)) state_nxt = FULL;
                    else if (pop && !push && level == LW'(1))    state_nxt = EMPTY;
                end
                FULL:    if (pop) state_nxt = PARTIAL;
                default: state_nxt = EMPTY;
            endcase
        end
    end

`ifdef FTEST_RX_PARITY_EN
    assign wdata = {^dec_b, dec_b, dec_sum};
    assign {out_par, out_b, out_sum} = rdata;
`else
    assign wdata = {dec_b, dec_sum};
    assign {out_b, out_sum} = rdata;
`endif

    ftest_rx_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level)
    );

endmodule

// File: tb/tb_ftest_rx.sv
// Scoreboard bench for ftest_rx: driver queues hand-computed results, monitor pops and compares.
module tb_ftest_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_z;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_b;
    logic [7:0] out_sum;
    logic [2:0] level;
`ifdef FTEST_RX_PARITY_EN
    logic       out_par;
`endif

    ftest_rx dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_sum   (out_sum),
        .level     (level)
`ifdef FTEST_RX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    // Directed vectors {a, z, b, sum}, b and sum worked out by hand.
    logic [31:0] vec [8] = '{
        32'h07_DF_20_27, 32'h8A_ED_12_9C, 32'h71_4D_B2_23, 32'h00_FF_00_00,
        32'hFF_00_FF_FE, 32'h10_F0_0F_1F, 32'h55_AA_55_AA, 32'h01_FE_01_02
    };

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb [$];
    logic [15:0] cur_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int unsigned i);
        logic [31:0] v;
        v       = vec[i];
        in_a    = v[31:24];
        in_z    = v[23:16];
        cur_exp = v[15:0];
    endtask

    // One cycle: decide acceptance before the edge, update the scoreboard on it.
    task automatic tick();
        logic acc;
        logic fl;
        @(negedge clk);
        acc = in_valid && in_ready;
        fl  = flush;
        @(posedge clk);
        if (fl) sb.delete();
        else if (acc) sb.push_back(cur_exp);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_b), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                check("out_b", 32'(out_b), 32'(e[15:8]));
                check("out_sum", 32'(out_sum), 32'(e[7:0]));
`ifdef FTEST_RX_PARITY_EN
                check("out_par", 32'(out_par), 32'(^e[15:8]));
`endif
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_vec(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_b", 32'(out_b), 0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(in_ready), 1);

        // Decode with a consumer that is always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            set_vec(i);
            tick();
            check("latency_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("decode_drained", 32'(level), 0);

        // Fill with consumer stalled; the fifth word must be refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int unsigned i = 3; i < 7; i++) begin
            set_vec(i);
            tick();
        end
        check("full_level", 32'(level), 4);
        check("full_in_ready", 32'(in_ready), 0);
        set_vec(7);
        tick();
        check("full_no_accept", 32'(level), 4);
        out_ready = 1'b1;
        tick();
        check("no_pop_through", 32'(level), 3);
        check("ready_after_pop", 32'(in_ready), 1);
        in_valid = 1'b0;
        repeat (3) tick();
        check("fill_drained", 32'(level), 0);

        // Steady push/pop at level 2 across pointer wrap.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_vec(0);
        tick();
        set_vec(1);
        tick();
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            set_vec((i + 2) % 8);
            tick();
            check("steady_level", 32'(level), 2);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("steady_drained", 32'(level), 0);

        // Flush at level 3 with push and pop requested.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int unsigned i = 2; i < 5; i++) begin
            set_vec(i);
            tick();
        end
        check("preflush_level", 32'(level), 3);
        flush     = 1'b1;
        out_ready = 1'b1;
        set_vec(5);
        #1;
        check("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        set_vec(6);
        tick();
        in_valid = 1'b0;
        tick();

        // Asynchronous reset between edges at level 2.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_vec(0);
        tick();
        set_vec(1);
        tick();
        in_valid = 1'b0;
        check("prereset_level", 32'(level), 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_level", 32'(level), 0);
        check("async_out_b", 32'(out_b), 0);
        check("async_out_sum", 32'(out_sum), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_vec(2);
        tick();
        in_valid = 1'b0;
        check("post_reset_b", 32'(out_b), 32'hB2);
        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
